axi_xbar_1ton: RTL and testbench

- Parametrised AXI4 1-master-to-N-slave crossbar; replaces the fixed SoC/RTC read-only router between the CPU's LSU/IFU arbiter and the SoC/peripheral ports.
- Routes both read and write channels by a compile-time address map, with independent read and write FSMs.
- Unmapped addresses get a locally generated DECERR, so the core never hangs.

---
 rtl/axi_xbar_1ton_if.sv | 64 ++++++
 rtl/axi_xbar_1ton.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_xbar_1ton.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_xbar_1ton_if.sv
// AXI4 bundle for the 1-to-N crossbar; N packs N ports side by side.
// N=1 is the master port, N=NSLV the packed slave ports.
interface axi_xbar_1ton_if #(
  parameter int N      = 1,
  parameter int DATA_W = 32
) ();
  localparam int STRB_W = DATA_W / 8;

  logic [N*32-1:0]     araddr;
  logic [N*8-1:0]      arlen;
  logic [N*3-1:0]      arsize;
  logic [N*2-1:0]      arburst;
  logic [N-1:0]        arvalid;
  logic [N-1:0]        arready;

  logic [N*DATA_W-1:0] rdata;
  logic [N*2-1:0]      rresp;
  logic [N-1:0]        rlast;
  logic [N-1:0]        rvalid;
  logic [N-1:0]        rready;

  logic [N*32-1:0]     awaddr;
  logic [N*8-1:0]      awlen;
  logic [N*3-1:0]      awsize;
  logic [N*2-1:0]      awburst;
  logic [N-1:0]        awvalid;
  logic [N-1:0]        awready;

  logic [N*DATA_W-1:0] wdata;
  logic [N*STRB_W-1:0] wstrb;
  logic [N-1:0]        wlast;
  logic [N-1:0]        wvalid;
  logic [N-1:0]        wready;

  logic [N*2-1:0]      bresp;
  logic [N-1:0]        bvalid;
  logic [N-1:0]        bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_xbar_1ton.sv
// AXI4 1-master to N-slave crossbar, address-mapped, with
// independent read/write FSMs and local DECERR for unmapped targets.
module axi_xbar_1ton #(
  parameter int              NSLV   = 3,
  parameter int              DATA_W = 32,
  parameter logic [NSLV*32-1:0] BASE = '0,
  parameter logic [NSLV*32-1:0] SIZE = '0,
  parameter int              CHK_WR = 1,
  parameter logic [NSLV-1:0] WR_EN  = '1
) (
  input logic              clk,
  input logic              rst,
  axi_xbar_1ton_if.slave   m,
  axi_xbar_1ton_if.master  s
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SW     = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    R_IDLE, R_AR, R_DATA, R_ERR
  } r_state_e;

  typedef enum logic [2:0] {
    W_IDLE, W_AW, W_DATA, W_RESP, W_ERR_D, W_ERR_B
  } w_state_e;

  function automatic logic [SW:0] decode(input logic [31:0] a);
    logic [SW-1:0] sel;
    logic          hit;
    logic [31:0]   b;
    logic [31:0]   z;
    sel = '0;
    hit = 1'b0;
    // walk downward so the lowest matching index wins
    for (int i = NSLV - 1; i >= 0; i--) begin
      b = BASE[32*i +: 32];
      z = SIZE[32*i +: 32];
      if (z != 32'd0 && a >= b && (a - b) < z) begin
        hit = 1'b1;
        sel = i[SW-1:0];
      end
    end
    return {hit, sel};
  endfunction

  r_state_e      r_state_q, r_state_d;
  logic [SW-1:0] rsel_q, rsel_d;
  logic [7:0]    rlen_q, rlen_d;
  logic [7:0]    rcnt_q, rcnt_d;
  logic          racc_q, racc_d;
  logic [SW:0]   rdec;
  logic          rlast_e;

  w_state_e      w_state_q, w_state_d;
  logic [SW-1:0] wsel_q, wsel_d;
  logic          wacc_q, wacc_d;
  logic [SW:0]   wdec;
  logic          werr;

  assign rdec    = decode(m.araddr);
  assign wdec    = decode(m.awaddr);
  assign werr    = !wdec[SW] ||
                   (CHK_WR != 0 && !WR_EN[wdec[SW-1:0]]);
  assign rlast_e = (rcnt_q == rlen_q);

  always_comb begin
    r_state_d = r_state_q;
    rsel_d    = rsel_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    racc_d    = racc_q;
    m.arready = 1'b0;
    m.rdata   = '0;
    m.rresp   = '0;
    m.rlast   = 1'b0;
    m.rvalid  = 1'b0;
    s.araddr  = '0;
    s.arlen   = '0;
    s.arsize  = '0;
    s.arburst = '0;
    s.arvalid = '0;
    s.rready  = '0;
    if (rst) begin
      r_state_d = R_IDLE;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (m.arvalid) begin
            rsel_d    = rdec[SW-1:0];
            rlen_d    = m.arlen;
            rcnt_d    = '0;
            racc_d    = 1'b0;
            r_state_d = rdec[SW] ? R_AR : R_ERR;
          end
        end
        R_AR: begin
          s.araddr          = {NSLV{m.araddr}};
          s.arlen           = {NSLV{m.arlen}};
          s.arsize          = {NSLV{m.arsize}};
          s.arburst         = {NSLV{m.arburst}};
          s.arvalid[rsel_q] = m.arvalid;
          m.arready         = s.arready[rsel_q];
          if (m.arvalid && s.arready[rsel_q])
            r_state_d = R_DATA;
        end
        R_DATA: begin
          m.rvalid         = s.rvalid[rsel_q];
          s.rready[rsel_q] = m.rready;
          if (s.rvalid[rsel_q]) begin
            m.rdata = s.rdata[rsel_q*DATA_W +: DATA_W];
            m.rresp = s.rresp[rsel_q*2 +: 2];
            m.rlast = s.rlast[rsel_q];
          end
          if (s.rvalid[rsel_q] && m.rready && s.rlast[rsel_q])
            r_state_d = R_IDLE;
        end
        R_ERR: begin
          if (!racc_q) begin
            m.arready = 1'b1;
            if (m.arvalid) racc_d = 1'b1;
          end else begin
            m.rvalid = 1'b1;
            m.rresp  = 2'b11;
            m.rlast  = rlast_e;
            if (m.rready) begin
              if (rlast_e) r_state_d = R_IDLE;
              else rcnt_d = rcnt_q + 8'd1;
            end
          end
        end
        default: r_state_d = R_IDLE;
      endcase
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    wsel_d    = wsel_q;
    wacc_d    = wacc_q;
    m.awready = 1'b0;
    m.wready  = 1'b0;
    m.bresp   = '0;
    m.bvalid  = 1'b0;
    s.awaddr  = '0;
    s.awlen   = '0;
    s.awsize  = '0;
    s.awburst = '0;
    s.awvalid = '0;
    s.wdata   = '0;
    s.wstrb   = '0;
    s.wlast   = '0;
    s.wvalid  = '0;
    s.bready  = '0;
    if (rst) begin
      w_state_d = W_IDLE;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (m.awvalid) begin
            wsel_d    = wdec[SW-1:0];
            wacc_d    = 1'b0;
            w_state_d = werr ? W_ERR_D : W_AW;
          end
        end
        W_AW: begin
          s.awaddr[wsel_q*32 +: 32] = m.awaddr;
          s.awlen[wsel_q*8 +: 8]    = m.awlen;
          s.awsize[wsel_q*3 +: 3]   = m.awsize;
          s.awburst[wsel_q*2 +: 2]  = m.awburst;
          s.awvalid[wsel_q]         = m.awvalid;
          m.awready                 = s.awready[wsel_q];
          if (m.awvalid && s.awready[wsel_q])
            w_state_d = W_DATA;
        end
        W_DATA: begin
          s.wdata[wsel_q*DATA_W +: DATA_W] = m.wdata;
          s.wstrb[wsel_q*STRB_W +: STRB_W] = m.wstrb;
          s.wlast[wsel_q]  = m.wlast;
          s.wvalid[wsel_q] = m.wvalid;
          m.wready         = s.wready[wsel_q];
          if (m.wvalid && s.wready[wsel_q] && m.wlast)
            w_state_d = W_RESP;
        end
        W_RESP: begin
          m.bvalid         = s.bvalid[wsel_q];
          s.bready[wsel_q] = m.bready;
          if (s.bvalid[wsel_q]) m.bresp = s.bresp[wsel_q*2 +: 2];
          if (s.bvalid[wsel_q] && m.bready)
            w_state_d = W_IDLE;
        end
        W_ERR_D: begin
          // W is held off until the AW beat has been taken
          if (!wacc_q) begin
            m.awready = 1'b1;
            if (m.awvalid) wacc_d = 1'b1;
          end else begin
            m.wready = 1'b1;
            if (m.wvalid && m.wlast) w_state_d = W_ERR_B;
          end
        end
        W_ERR_B: begin
          m.bvalid = 1'b1;
          m.bresp  = 2'b11;
          if (m.bready) w_state_d = W_IDLE;
        end
        default: w_state_d = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
    end
    rsel_q <= rsel_d;
    rlen_q <= rlen_d;
    rcnt_q <= rcnt_d;
    racc_q <= racc_d;
    wsel_q <= wsel_d;
    wacc_q <= wacc_d;
  end

`ifdef XBAR_DPI
  always @(posedge clk) begin
    for (int i = 0; i < NSLV; i++) begin
      if (!rst && s.rvalid[i] && s.rready[i] && s.rresp[2*i +: 2] != 2'b00)
        $error("xbar: slave %0d rresp=%0b", i, s.rresp[2*i +: 2]);
      if (!rst && s.bvalid[i] && s.bready[i] && s.bresp[2*i +: 2] != 2'b00)
        $error("xbar: slave %0d bresp=%0b", i, s.bresp[2*i +: 2]);
    end
  end
`endif
endmodule

// File: tb/tb_axi_xbar_1ton.sv
// Directed bench for axi_xbar_1ton: routing, bursts, DECERR paths,
// concurrent read/write and mid-burst reset.
module tb_axi_xbar_1ton;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  axi_xbar_1ton_if #(.N(1), .DATA_W(32)) mi ();
  axi_xbar_1ton_if #(.N(3), .DATA_W(32)) si ();

  axi_xbar_1ton #(
    .NSLV  (3),
    .DATA_W(32),
    .BASE  ({32'h0200_0000, 32'hA000_0000, 32'h8000_0000}),
    .SIZE  ({32'h0001_0000, 32'h0000_1000, 32'h0800_0000}),
    .CHK_WR(1),
    .WR_EN (3'b101)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m  (mi),
    .s  (si)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    mi.araddr = '0; mi.arlen = '0; mi.arsize = 3'd2;
    mi.arburst = 2'b01; mi.arvalid = 0; mi.rready = 0;
    mi.awaddr = '0; mi.awlen = '0; mi.awsize = 3'd2;
    mi.awburst = 2'b01; mi.awvalid = 0;
    mi.wdata = '0; mi.wstrb = '0; mi.wlast = 0; mi.wvalid = 0;
    mi.bready = 0;
    si.arready = '0; si.rdata = '0; si.rresp = '0;
    si.rlast = '0; si.rvalid = '0;
    si.awready = '0; si.wready = '0;
    si.bresp = '0; si.bvalid = '0;

    repeat (2) cyc();
    chk("rst_arready", mi.arready, 0);
    chk("rst_rvalid", mi.rvalid, 0);
    chk("rst_bvalid", mi.bvalid, 0);
    chk("rst_wready", mi.wready, 0);
    chk("rst_s_arvalid", si.arvalid, 0);
    chk("rst_s_awvalid", si.awvalid, 0);
    rst = 1'b0;
    cyc();

    // single read to slave 0
    mi.araddr = 32'h8000_0010; mi.arlen = 0; mi.arvalid = 1;
    si.arready = 3'b111;
    #1;
    chk("t1_idle_s_arvalid", si.arvalid, 3'b000);
    chk("t1_idle_arready", mi.arready, 0);
    cyc();
    chk("t1_s_arvalid", si.arvalid, 3'b001);
    chk("t1_arready", mi.arready, 1);
    chk("t1_s_araddr", si.araddr[31:0], 32'h8000_0010);
    cyc();
    mi.arvalid = 0;
    si.rdata = {32'h0, 32'h1111_1111, 32'hDEAD_BEEF};
    si.rvalid = 3'b011; si.rlast = 3'b011; mi.rready = 1;
    #1;
    chk("t1_rvalid", mi.rvalid, 1);
    chk("t1_rdata", mi.rdata, 32'hDEAD_BEEF);
    chk("t1_rlast", mi.rlast, 1);
    chk("t1_s_rready", si.rready, 3'b001);
    chk("t1_s_arvalid_off", si.arvalid, 0);
    cyc();
    si.rvalid = 0; si.rlast = 0; mi.rready = 0;
    #1;
    chk("t1_done_rvalid", mi.rvalid, 0);
    chk("t1_done_s_rready", si.rready, 0);

    // 4-beat burst to slave 2, rready toggling
    mi.araddr = 32'h0200_0048; mi.arlen = 3; mi.arvalid = 1;
    cyc();
    #1;
    chk("t2_s_arvalid", si.arvalid, 3'b100);
    chk("t2_s_arlen", si.arlen[23:16], 3);
    cyc();
    mi.arvalid = 0;
    for (int k = 0; k < 4; k++) begin
      si.rdata[95:64] = 32'hB000_0000 + k;
      si.rvalid = 3'b100;
      si.rlast = (k == 3) ? 3'b100 : 3'b000;
      mi.rready = 0;
      #1;
      chk("t2_rdata_hold", mi.rdata, 32'hB000_0000 + k);
      chk("t2_s_rready_lo", si.rready, 0);
      cyc();
      mi.rready = 1;
      #1;
      chk("t2_s_rready_hi", si.rready, 3'b100);
      chk("t2_rlast", mi.rlast, (k == 3) ? 1 : 0);
      cyc();
    end
    si.rvalid = 0; si.rlast = 0; mi.rready = 0;
    #1;
    chk("t2_done_rvalid", mi.rvalid, 0);

    // unmapped read, 2 error beats
    mi.araddr = 32'h1000_0000; mi.arlen = 1; mi.arvalid = 1;
    cyc();
    #1;
    chk("t3_arready", mi.arready, 1);
    chk("t3_s_arvalid", si.arvalid, 0);
    cyc();
    mi.arvalid = 0;
    #1;
    chk("t3_b1_rvalid", mi.rvalid, 1);
    chk("t3_b1_rresp", mi.rresp, 2'b11);
    chk("t3_b1_rdata", mi.rdata, 0);
    chk("t3_b1_rlast", mi.rlast, 0);
    chk("t3_b1_arready", mi.arready, 0);
    mi.rready = 1;
    cyc();
    #1;
    chk("t3_b2_rlast", mi.rlast, 1);
    chk("t3_b2_rresp", mi.rresp, 2'b11);
    chk("t3_s_arvalid2", si.arvalid, 0);
    cyc();
    mi.rready = 0;
    #1;
    chk("t3_done_rvalid", mi.rvalid, 0);

    // write to write-protected slave 1
    mi.awaddr = 32'hA000_0004; mi.awlen = 0; mi.awvalid = 1;
    mi.wdata = 32'h1234_5678; mi.wstrb = 4'b0011;
    mi.wlast = 1; mi.wvalid = 1;
    si.awready = 3'b111; si.wready = 3'b111;
    #1;
    chk("t4_idle_awready", mi.awready, 0);
    chk("t4_idle_wready", mi.wready, 0);
    cyc();
    #1;
    chk("t4_awready", mi.awready, 1);
    chk("t4_wready_pre", mi.wready, 0);
    chk("t4_s_awvalid", si.awvalid, 0);
    cyc();
    mi.awvalid = 0;
    #1;
    chk("t4_wready", mi.wready, 1);
    chk("t4_s_wvalid", si.wvalid, 0);
    chk("t4_bvalid_pre", mi.bvalid, 0);
    cyc();
    mi.wvalid = 0; mi.wlast = 0;
    #1;
    chk("t4_bvalid", mi.bvalid, 1);
    chk("t4_bresp", mi.bresp, 2'b11);
    mi.bready = 1;
    cyc();
    mi.bready = 0;
    #1;
    chk("t4_done_bvalid", mi.bvalid, 0);

    // concurrent read slave 0 and write slave 2
    mi.araddr = 32'h8000_0000; mi.arlen = 0; mi.arvalid = 1;
    mi.awaddr = 32'h0200_0000; mi.awlen = 0; mi.awvalid = 1;
    mi.wdata = 32'hCAFE_F00D; mi.wstrb = 4'hF;
    mi.wlast = 1; mi.wvalid = 1;
    cyc();
    #1;
    chk("t5_s_arvalid", si.arvalid, 3'b001);
    chk("t5_s_awvalid", si.awvalid, 3'b100);
    chk("t5_awready", mi.awready, 1);
    chk("t5_s_awaddr2", si.awaddr[95:64], 32'h0200_0000);
    chk("t5_s_wvalid_pre", si.wvalid, 0);
    chk("t5_wready_pre", mi.wready, 0);
    cyc();
    mi.arvalid = 0; mi.awvalid = 0;
    si.rdata = {32'h0, 32'h0, 32'h5555_AAAA};
    si.rvalid = 3'b001; si.rlast = 3'b001; mi.rready = 1;
    #1;
    chk("t5_s_wvalid", si.wvalid, 3'b100);
    chk("t5_wready", mi.wready, 1);
    chk("t5_s_wstrb", si.wstrb[11:8], 4'hF);
    chk("t5_s_wdata", si.wdata[95:64], 32'hCAFE_F00D);
    chk("t5_s_wdata0", si.wdata[31:0], 0);
    chk("t5_rdata", mi.rdata, 32'h5555_AAAA);
    chk("t5_s_rready", si.rready, 3'b001);
    cyc();
    mi.wvalid = 0; mi.wlast = 0;
    si.rvalid = 0; si.rlast = 0; mi.rready = 0;
    si.bvalid = 3'b110; si.bresp = 6'b00_11_00; mi.bready = 1;
    #1;
    chk("t5_bvalid", mi.bvalid, 1);
    chk("t5_bresp", mi.bresp, 2'b00);
    chk("t5_s_bready", si.bready, 3'b100);
    chk("t5_r_idle", mi.rvalid, 0);
    cyc();
    si.bvalid = 0; si.bresp = 0; mi.bready = 0;
    #1;
    chk("t5_done_bvalid", mi.bvalid, 0);
    chk("t5_done_s_bready", si.bready, 0);

    // reset during beat 2 of a 4-beat read
    mi.araddr = 32'h0200_0000; mi.arlen = 3; mi.arvalid = 1;
    cyc();
    cyc();
    mi.arvalid = 0;
    si.rdata = {32'h7777_0001, 64'h0};
    si.rvalid = 3'b100; mi.rready = 1;
    cyc();
    si.rdata = {32'h7777_0002, 64'h0};
    rst = 1;
    #1;
    chk("t6_rst_rvalid", mi.rvalid, 0);
    chk("t6_rst_s_rready", si.rready, 0);
    chk("t6_rst_rdata", mi.rdata, 0);
    cyc();
    rst = 0;
    si.rvalid = 0; mi.rready = 0;
    #1;
    chk("t6_post_rvalid", mi.rvalid, 0);
    chk("t6_post_arready", mi.arready, 0);
    chk("t6_post_s_arvalid", si.arvalid, 0);
    chk("t6_post_s_rready", si.rready, 0);
    mi.araddr = 32'h8000_0020; mi.arlen = 0; mi.arvalid = 1;
    cyc();
    #1;
    chk("t6_new_s_arvalid", si.arvalid, 3'b001);
    chk("t6_new_arready", mi.arready, 1);
    cyc();
    mi.arvalid = 0;
    si.rdata = {64'h0, 32'h0BAD_CAFE};
    si.rvalid = 3'b001; si.rlast = 3'b001; mi.rready = 1;
    #1;
    chk("t6_new_rdata", mi.rdata, 32'h0BAD_CAFE);
    chk("t6_new_rlast", mi.rlast, 1);
    cyc();
    si.rvalid = 0; si.rlast = 0; mi.rready = 0;
    #1;
    chk("t6_done_rvalid", mi.rvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
